// File: rtl/carry_pkg.sv
// carry_pkg: shared constants and segment arithmetic for the pipelined
// carry chain.
//   MAX_WIDTH           : largest supported chain length
//   nseg(width, seg)    : number of segments, ceil(width / seg)
//   seg_lo(k, seg)      : lowest bit index of segment k
//   seg_hi(k, seg, w)   : highest bit index of segment k (last one may be short)
package carry_pkg;

    localparam int MAX_WIDTH = 256;

    function automatic int nseg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

    function automatic int seg_hi(input int k, input int seg, input int width);
        return (((k + 1) * seg) < width) ? ((k + 1) * seg - 1) : (width - 1);
    endfunction

endpackage

// File: rtl/carry_chain_pipe_if.sv
// carry_chain_pipe_if: word bus of the pipelined carry chain.
//   CE     : clock enable, a global stall; low freezes every pipeline register
//   VI     : input word valid
//   CI     : carry into bit 0
//   DI, S  : per-bit generate value and propagate select
//   VO     : output word valid
//   O, CO  : per-bit sum and per-bit carry-out
//
// Handshake: valid-only, there is no ready. A word is accepted on every rising
// edge where CE=1 and VI=1; it leaves with VO=1 exactly NSEG CE=1 edges later.
// CE=0 is the only form of flow control and it stalls both ends together.
interface carry_chain_pipe_if #(
    parameter int WIDTH = 16
);
    logic             CE;
    logic             VI;
    logic             CI;
    logic [WIDTH-1:0] DI;
    logic [WIDTH-1:0] S;
    logic             VO;
    logic [WIDTH-1:0] O;
    logic [WIDTH-1:0] CO;

    modport master (output CE, VI, CI, DI, S, input VO, O, CO);
    modport slave  (input CE, VI, CI, DI, S, output VO, O, CO);
endinterface

// File: rtl/carry_seg.sv
// carry_seg: combinational N-cell MUXCY/XORCY carry segment.
//   ci : carry into cell 0
//   s  : per-cell propagate select
//   di : per-cell generate value, taken when s is low
//   o  : per-cell sum, s ^ carry-in
//   co : per-cell carry-out; co[N-1] is the segment's carry-out
module carry_seg #(
    parameter int N = 4
) (
    input  logic         ci,
    input  logic [N-1:0] s,
    input  logic [N-1:0] di,
    output logic [N-1:0] o,
    output logic [N-1:0] co
);

    always_comb begin
        logic c;
        c  = ci;
        o  = '0;
        co = '0;
        for (int i = 0; i < N; i++) begin
            o[i]  = s[i] ^ c;
            c     = s[i] ? c : di[i];
            co[i] = c;
        end
    end

endmodule

// File: rtl/carry_chain_pipe.sv
// carry_chain_pipe: WIDTH-bit carry chain cut into SEG-bit segments with a
// register stage in front of each segment. Latency is NSEG CE-qualified edges,
// throughput one word per CE-qualified edge.
//   C    : clock, rising edge
//   CLR  : asynchronous active-high clear of every pipeline register
//   bus  : carry_chain_pipe_if slave (CE, VI, CI, DI, S in; VO, O, CO out)
//
// Each stage register holds one full-width "mixed" word: bits of segments
// already evaluated carry their sum/carry-out, bits of segments not yet
// evaluated carry their raw select/generate. This gives the input skew and the
// output deskew in a single array. The last segment is evaluated straight
// from the last stage register, so inputs never reach outputs combinationally.
module carry_chain_pipe
    import carry_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                C,
    input  logic                CLR,
    carry_chain_pipe_if.slave   bus
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("carry_chain_pipe: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (SEG < 1 || SEG > WIDTH) begin : g_bad_seg
        $error("carry_chain_pipe: SEG=%0d outside 1..WIDTH", SEG);
    end

    // ps: sum bits (finished segments) / select bits (pending segments)
    // pd: carry-out bits (finished segments) / generate bits (pending segments)
    logic [NSEG-1:0][WIDTH-1:0] ps_r, pd_r;
    logic [NSEG-1:0][WIDTH-1:0] ps_m, pd_m;  // stage word after its own segment
    logic [NSEG-1:0]            c_r;         // carry into the stage's segment
    logic [NSEG-1:0]            v_r;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = seg_lo(k, SEG);
        localparam int HI = seg_hi(k, SEG, WIDTH);
        localparam int N  = HI - LO + 1;

        logic [N-1:0] seg_o, seg_co;

        carry_seg #(.N(N)) u_seg (
            .ci (c_r[k]),
            .s  (ps_r[k][HI:LO]),
            .di (pd_r[k][HI:LO]),
            .o  (seg_o),
            .co (seg_co)
        );

        assign ps_m[k][HI:LO] = seg_o;
        assign pd_m[k][HI:LO] = seg_co;

        if (LO > 0) begin : g_below
            assign ps_m[k][LO-1:0] = ps_r[k][LO-1:0];
            assign pd_m[k][LO-1:0] = pd_r[k][LO-1:0];
        end
        if (HI < WIDTH - 1) begin : g_above
            assign ps_m[k][WIDTH-1:HI+1] = ps_r[k][WIDTH-1:HI+1];
            assign pd_m[k][WIDTH-1:HI+1] = pd_r[k][WIDTH-1:HI+1];
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            ps_r <= '0;
            pd_r <= '0;
            c_r  <= '0;
            v_r  <= '0;
        end else if (bus.CE) begin
            ps_r[0] <= bus.S;
            pd_r[0] <= bus.DI;
            c_r[0]  <= bus.CI;
            v_r[0]  <= bus.VI;
            for (int k = 1; k < NSEG; k++) begin
                ps_r[k] <= ps_m[k-1];
                pd_r[k] <= pd_m[k-1];
                // carry-out of segment k-1 is the carry-out of its top bit
                c_r[k]  <= pd_m[k-1][k*SEG-1];
                v_r[k]  <= v_r[k-1];
            end
        end
    end

    // After CLR every stage word is zero, so the last segment sees s=0, di=0,
    // c=0 and O/CO evaluate to zero without waiting for an edge.
    assign bus.VO = v_r[NSEG-1];
    assign bus.O  = ps_m[NSEG-1];
    assign bus.CO = pd_m[NSEG-1];

endmodule

// File: tb/tb_carry_chain_pipe.sv
// tb_carry_chain_pipe: directed table of carry-chain vectors on a 16/4
// instance with an expected-queue scoreboard, hand-written latency, stall and
// reset sequences, a 10/4 partial-segment instance against a bit-level model,
// and an 8/8 single-stage instance.
module tb_carry_chain_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carry_chain_pipe_if #(.WIDTH(16)) b16 ();
    carry_chain_pipe_if #(.WIDTH(10)) b10 ();
    carry_chain_pipe_if #(.WIDTH(8))  b8 ();

    carry_chain_pipe #(.WIDTH(16), .SEG(4)) dut16 (.C(clk), .CLR(rst), .bus(b16));
    carry_chain_pipe #(.WIDTH(10), .SEG(4)) dut10 (.C(clk), .CLR(rst), .bus(b10));
    carry_chain_pipe #(.WIDTH(8),  .SEG(8)) dut8  (.C(clk), .CLR(rst), .bus(b8));

    // ---------------- bookkeeping ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] s;
        logic [15:0] di;
        logic        ci;
        logic [15:0] o;
        logic [15:0] co;
    } vec_t;

    vec_t tbl[8];

    // ---------------- scoreboard for the 16-bit instance ----------------
    logic [31:0] exp_q[$];   // {O, CO}
    int unsigned tgt_q[$];   // CE-edge count at which the word must be visible
    int unsigned en16 = 0;
    int unsigned last16 = 0;

    always @(posedge clk) begin
        if (!rst && b16.CE) en16++;
    end

    always @(negedge clk) begin
        if (rst) begin
            last16 = en16;
        end else if (en16 != last16) begin
            last16 = en16;
            if (b16.VO) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_vo", 32'(b16.VO), 32'd0);
                end else begin
                    chk("sb_data", {b16.O, b16.CO}, exp_q.pop_front());
                    chk("sb_latency", en16, tgt_q.pop_front());
                end
            end else if (tgt_q.size() > 0 && tgt_q[0] == en16) begin
                chk("sb_missing_vo", 32'(b16.VO), 32'd1);
                void'(exp_q.pop_front());
                void'(tgt_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue16(input vec_t v);
        b16.CE = 1'b1;
        b16.VI = 1'b1;
        b16.S  = v.s;
        b16.DI = v.di;
        b16.CI = v.ci;
        exp_q.push_back({v.o, v.co});
        tgt_q.push_back(en16 + 4);
        tick();
    endtask

    // With CE=0 the valid bit and data are junk that must be ignored.
    task automatic idle16(input logic ce);
        b16.CE = ce;
        b16.VI = ce ? 1'b0 : 1'($urandom_range(0, 1));
        b16.S  = 16'($urandom);
        b16.DI = 16'($urandom);
        b16.CI = 1'($urandom_range(0, 1));
        tick();
    endtask

    function automatic logic [19:0] model10(input logic [9:0] s, input logic [9:0] di,
                                            input logic ci);
        logic [9:0] o, co;
        logic c;
        c = ci;
        for (int i = 0; i < 10; i++) begin
            o[i]  = s[i] ^ c;
            co[i] = s[i] ? c : di[i];
            c     = co[i];
        end
        return {o, co};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog expired");
    end

    localparam int NW = 1000;
    logic [9:0] s10[NW];
    logic [9:0] d10[NW];
    logic       c10[NW];
    logic       v10[NW];

    // ---------------- test sequence ----------------
    initial begin
        //            s         di        ci    o         co
        tbl[0] = '{16'hFFFE, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};  // FFFF+0001
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'hFFFF};  // propagate, CI=1
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};  // propagate, CI=0
        tbl[3] = '{16'h5115, 16'h1234, 1'b0, 16'h5555, 16'h0220};  // 1234+4321
        tbl[4] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 16'h8000};  // 8000+8000
        tbl[5] = '{16'h00FE, 16'h00FF, 1'b0, 16'h0100, 16'h00FF};  // 00FF+0001
        tbl[6] = '{16'h0000, 16'hA5A5, 1'b1, 16'h4B4B, 16'hA5A5};  // pure generate
        tbl[7] = '{16'hFFF0, 16'h000F, 1'b0, 16'h000E, 16'hFFFF};  // carry across all cuts

        b16.CE = 0; b16.VI = 0; b16.S = '0; b16.DI = '0; b16.CI = 0;
        b10.CE = 0; b10.VI = 0; b10.S = '0; b10.DI = '0; b10.CI = 0;
        b8.CE  = 0; b8.VI  = 0; b8.S  = '0; b8.DI  = '0; b8.CI  = 0;

        // reset state, before any clock edge
        rst = 1'b1;
        #1;
        chk("rst_vo16", 32'(b16.VO), 32'd0);
        chk("rst_o16",  32'(b16.O),  32'd0);
        chk("rst_co16", 32'(b16.CO), 32'd0);
        chk("rst_vo10", 32'(b10.VO), 32'd0);
        chk("rst_vo8",  32'(b8.VO),  32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();

        // single adder word: exact latency of 4
        issue16(tbl[0]);
        idle16(1'b1);
        idle16(1'b1);
        chk("adder_vo_c3", 32'(b16.VO), 32'd0);
        idle16(1'b1);
        chk("adder_vo_c4", 32'(b16.VO), 32'd1);
        chk("adder_o_c4",  32'(b16.O),  32'h0000);
        chk("adder_co_c4", 32'(b16.CO), 32'hFFFF);
        idle16(1'b1);
        chk("adder_vo_c5", 32'(b16.VO), 32'd0);

        // whole table back-to-back; scoreboard checks data and latency
        foreach (tbl[i]) issue16(tbl[i]);
        repeat (6) idle16(1'b1);

        // CE stall of 3 edges after the 2nd edge, then hold at the output
        issue16(tbl[3]);
        idle16(1'b1);
        repeat (3) idle16(1'b0);
        idle16(1'b1);
        chk("stall_vo_e6", 32'(b16.VO), 32'd0);
        idle16(1'b1);
        chk("stall_vo_e7", 32'(b16.VO), 32'd1);
        chk("stall_o_e7",  32'(b16.O),  32'h5555);
        chk("stall_co_e7", 32'(b16.CO), 32'h0220);
        for (int i = 0; i < 2; i++) begin
            idle16(1'b0);
            chk("hold_vo", 32'(b16.VO), 32'd1);
            chk("hold_o",  32'(b16.O),  32'h5555);
            chk("hold_co", 32'(b16.CO), 32'h0220);
        end
        idle16(1'b1);
        chk("no_dup_vo", 32'(b16.VO), 32'd0);

        // reset mid-flight: first word visible, two more in flight
        issue16(tbl[5]);
        issue16(tbl[2]);
        issue16(tbl[1]);
        idle16(1'b1);
        chk("pre_rst_vo", 32'(b16.VO), 32'd1);
        chk("pre_rst_o",  32'(b16.O),  32'h0100);
        @(negedge clk);
        #1;
        b16.CE = 1'b1;
        b16.VI = 1'b1;  // a word presented while CLR is high must be dropped
        rst = 1'b1;
        exp_q.delete();
        tgt_q.delete();
        #1;
        chk("mid_rst_vo", 32'(b16.VO), 32'd0);
        chk("mid_rst_o",  32'(b16.O),  32'd0);
        chk("mid_rst_co", 32'(b16.CO), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle16(1'b1);
            chk("post_rst_vo", 32'(b16.VO), 32'd0);
        end
        issue16(tbl[6]);
        idle16(1'b1);
        idle16(1'b1);
        chk("rst_new_vo_c3", 32'(b16.VO), 32'd0);
        idle16(1'b1);
        chk("rst_new_vo_c4", 32'(b16.VO), 32'd1);
        chk("rst_new_o_c4",  32'(b16.O),  32'h4B4B);
        repeat (2) idle16(1'b1);
        b16.CE = 1'b0;

        // partial last segment, WIDTH=10 SEG=4: fixed latency 3 with CE=1
        s10[0] = 10'h3FF; d10[0] = 10'h000; c10[0] = 1'b1; v10[0] = 1'b1;
        for (int i = 1; i < NW; i++) begin
            s10[i] = 10'($urandom);
            d10[i] = 10'($urandom);
            c10[i] = 1'($urandom_range(0, 1));
            v10[i] = ($urandom_range(0, 3) != 0);
        end
        for (int j = 0; j < NW + 3; j++) begin
            b10.CE = 1'b1;
            if (j < NW) begin
                b10.VI = v10[j]; b10.S = s10[j]; b10.DI = d10[j]; b10.CI = c10[j];
            end else begin
                b10.VI = 1'b0;
            end
            tick();
            if (j + 1 >= 3) begin
                int w;
                w = j + 1 - 3;
                chk("w10_vo", 32'(b10.VO), 32'(v10[w]));
                if (w == 0) begin
                    chk("w10_first_o",  32'(b10.O),  32'h000);
                    chk("w10_first_co", 32'(b10.CO), 32'h3FF);
                end else if (v10[w]) begin
                    chk("w10_data", 32'({b10.O, b10.CO}), 32'(model10(s10[w], d10[w], c10[w])));
                end
            end else begin
                chk("w10_vo_fill", 32'(b10.VO), 32'd0);
            end
        end
        b10.CE = 1'b0;

        // SEG=WIDTH: single register stage, latency 1
        b8.CE = 1'b1; b8.VI = 1'b1; b8.S = 8'hFF; b8.DI = 8'h00; b8.CI = 1'b1;
        tick();
        chk("w8_vo_a", 32'(b8.VO), 32'd1);
        chk("w8_o_a",  32'(b8.O),  32'h00);
        chk("w8_co_a", 32'(b8.CO), 32'hFF);
        b8.S = 8'h0F; b8.DI = 8'hF0; b8.CI = 1'b0;
        tick();
        chk("w8_vo_b", 32'(b8.VO), 32'd1);
        chk("w8_o_b",  32'(b8.O),  32'hEF);
        chk("w8_co_b", 32'(b8.CO), 32'hF0);
        b8.VI = 1'b0;
        tick();
        chk("w8_vo_c", 32'(b8.VO), 32'd0);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
